// File: rtl/dmem_responder.sv
// Data-port responder for the MEM stage: turns LW/SW/LL/SC into RAM transactions,
// returns dhit/dmemload, and keeps the LL/SC link register coherent with snooped writes.
module dmem_responder #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dmem_err,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  output logic        link_valid
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [1:0]       RAM_ACCESS  = 2'd2;
  localparam logic [1:0]       RAM_ERROR   = 2'd3;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic               err_q, err_d;
  logic               ren_q, ren_d;
  logic               wen_q, wen_d;
  logic               op_write_q, op_write_d;
  logic               op_atomic_q, op_atomic_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        store_q, store_d;
  logic [31:0]        load_q, load_d;
  logic               link_valid_q, link_valid_d;
  logic [29:0]        link_addr_q, link_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               snoop_hit;
  logic               sc_fail;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{dmemaddr[1:0], snoop_addr[1:0]};

  assign snoop_hit = snoop_valid && (snoop_addr[31:2] == link_addr_q);
  // A matching snoop in the same cycle as the SC check kills the reservation first.
  assign sc_fail   = !link_valid_q || snoop_hit || (link_addr_q != dmemaddr[31:2]);

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    op_write_d   = op_write_q;
    op_atomic_d  = op_atomic_q;
    addr_d       = addr_q;
    store_d      = store_q;
    load_d       = load_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    cnt_d        = cnt_q;

    if (snoop_hit) begin
      link_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (dmemWEN || dmemREN) begin
          addr_d      = dmemaddr[31:2];
          store_d     = dmemstore;
          op_write_d  = dmemWEN;
          op_atomic_d = datomic;
          if (dmemWEN && datomic && sc_fail) begin
            state_d      = RESP;
            load_d       = 32'd0;
            link_valid_d = 1'b0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            ren_d   = !dmemWEN;
            wen_d   = dmemWEN;
          end
        end
      end

      REQ: begin
        if (ramstate == RAM_ACCESS) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = RESP;
          if (op_write_q) begin
            if (op_atomic_q) begin
              load_d       = 32'd1;
              link_valid_d = 1'b0;
            end else if (addr_q == link_addr_q) begin
              link_valid_d = 1'b0;
            end
          end else begin
            load_d = ramload;
            // LL is ordered after any snoop landing in its completion cycle.
            if (op_atomic_q) begin
              link_addr_d  = addr_q;
              link_valid_d = 1'b1;
            end
          end
        end else if ((ramstate == RAM_ERROR) || (cnt_q == TIMEOUT_CNT)) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = RESP;
          err_d   = 1'b1;
          load_d  = 32'd0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      err_q        <= 1'b0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      op_write_q   <= 1'b0;
      op_atomic_q  <= 1'b0;
      addr_q       <= '0;
      store_q      <= '0;
      load_q       <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      op_write_q   <= op_write_d;
      op_atomic_q  <= op_atomic_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      load_q       <= load_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dhit       = (state_q == RESP);
  assign dmem_err   = err_q;
  assign dmemload   = load_q;
  assign ramREN     = ren_q;
  assign ramWEN     = wen_q;
  assign ramaddr    = {addr_q, 2'b00};
  assign ramstore   = store_q;
  assign link_valid = link_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses,
// a negedge monitor pops and compares on every dhit; a small RAM model drives ramstate.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmemREN, dmemWEN, datomic;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmem_err;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        snoop_valid;
  logic [31:0] snoop_addr;
  logic        link_valid;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct {
    string       name;
    logic [31:0] load;
    logic        err;
    logic        chk_load;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          dhit_total = 0;
  int          ren_total = 0;
  int          wen_total = 0;
  int          ram_mode = 0;
  int          busy_cycles = 0;
  int          wait_cnt = 0;
  logic [31:0] load_value = 32'd0;
  logic [31:0] seen_addr = 32'd0;
  logic [31:0] seen_store = 32'd0;

  always #5 clk = ~clk;

  dmem_responder #(.TIMEOUT(4), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .dmem_err(dmem_err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .link_valid(link_valid)
  );

  // RAM model: mode 0 = BUSY for busy_cycles then ACCESS, 1 = stuck BUSY, 2 = ERROR.
  initial begin
    ramstate = FREE;
    ramload  = 32'd0;
  end

  always @(negedge clk) begin
    if (ramREN) ren_total++;
    if (ramREN || ramWEN) begin
      if (ram_mode == 2) begin
        ramstate = ERROR;
      end else if (ram_mode == 1) begin
        ramstate = BUSY;
      end else if (wait_cnt < busy_cycles) begin
        ramstate = BUSY;
        wait_cnt++;
      end else begin
        ramstate  = ACCESS;
        ramload   = load_value;
        seen_addr = ramaddr;
        if (ramWEN) begin
          wen_total++;
          seen_store = ramstore;
        end
      end
    end else begin
      ramstate = FREE;
      wait_cnt = 0;
    end
  end

  // Monitor: every response strobe is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && dhit) begin
      dhit_total++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_dhit got dhit=1 load=%h want no response", dmemload);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.chk_load && (dmemload !== mon_e.load)) || (dmem_err !== mon_e.err)) begin
          errors++;
          $display("[TB] FAIL %s load got %h want %h err got %b want %b",
                   mon_e.name, dmemload, mon_e.load, dmem_err, mon_e.err);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  // Called right after a negedge; request is presented in "cycle 1".
  task automatic applyStimulus(input string name, input logic wen, input logic ren,
                               input logic atomic, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] exp_load,
                               input logic exp_err, input logic chk_load,
                               input int exp_cycles);
    exp_t e;
    int   waited;
    logic got;
    e.name = name; e.load = exp_load; e.err = exp_err; e.chk_load = chk_load;
    exp_q.push_back(e);
    dmemWEN = wen; dmemREN = ren; datomic = atomic;
    dmemaddr = addr; dmemstore = data;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 60) begin
      @(negedge clk);
      waited++;
      if (dhit) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout got no dhit want dhit within 60 cycles", name);
      void'(exp_q.pop_back());
    end else if (exp_cycles > 0) begin
      checkOutput({name, "_latency"}, 32'(waited + 1), 32'(exp_cycles));
    end
    dmemWEN = 1'b0; dmemREN = 1'b0; datomic = 1'b0;
    @(negedge clk);
  endtask

  task automatic snoopAfter(input int delay, input logic [31:0] addr);
    repeat (delay) @(negedge clk);
    snoop_valid = 1'b1;
    snoop_addr  = addr;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, r0, d0;
    rst = 1'b1;
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    dmemaddr = 32'd0; dmemstore = 32'd0;
    snoop_valid = 1'b0; snoop_addr = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_dhit",   32'(dhit), 32'd0);
    checkOutput("reset_ramren", 32'(ramREN), 32'd0);
    checkOutput("reset_link",   32'(link_valid), 32'd0);
    checkOutput("reset_load",   dmemload, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LW with two BUSY cycles, low address bits ignored
    load_value = 32'hDEADBEEF; busy_cycles = 2; r0 = ren_total;
    applyStimulus("lw_busy", 1'b0, 1'b1, 1'b0, 32'h103, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1, 5);
    checkOutput("lw_ren_cycles", 32'(ren_total - r0), 32'd3);
    checkOutput("lw_ramaddr", seen_addr, 32'h100);

    // LL then successful SC
    busy_cycles = 0; load_value = 32'h12345678;
    applyStimulus("ll_200", 1'b0, 1'b1, 1'b1, 32'h200, 32'd0, 32'h12345678, 1'b0, 1'b1, 3);
    checkOutput("ll_link_set", 32'(link_valid), 32'd1);
    w0 = wen_total;
    applyStimulus("sc_ok", 1'b1, 1'b0, 1'b1, 32'h200, 32'h5, 32'd1, 1'b0, 1'b1, 3);
    checkOutput("sc_ok_wen", 32'(wen_total - w0), 32'd1);
    checkOutput("sc_ok_store", seen_store, 32'h5);
    checkOutput("sc_ok_link", 32'(link_valid), 32'd0);

    // Snoop between LL and SC kills the link
    applyStimulus("ll_200b", 1'b0, 1'b1, 1'b1, 32'h200, 32'd0, 32'h12345678, 1'b0, 1'b1, 3);
    snoopAfter(0, 32'h200);
    checkOutput("snoop_link", 32'(link_valid), 32'd0);
    w0 = wen_total;
    applyStimulus("sc_snooped", 1'b1, 1'b0, 1'b1, 32'h200, 32'h6, 32'd0, 1'b0, 1'b1, 2);
    checkOutput("sc_snooped_wen", 32'(wen_total - w0), 32'd0);

    // SC to a different word fails
    applyStimulus("ll_200c", 1'b0, 1'b1, 1'b1, 32'h200, 32'd0, 32'h12345678, 1'b0, 1'b1, 3);
    applyStimulus("sc_wrong_addr", 1'b1, 1'b0, 1'b1, 32'h204, 32'h6, 32'd0, 1'b0, 1'b1, 2);

    // Local plain SW to the linked word kills the link
    applyStimulus("ll_200d", 1'b0, 1'b1, 1'b1, 32'h200, 32'd0, 32'h12345678, 1'b0, 1'b1, 3);
    applyStimulus("sw_200", 1'b1, 1'b0, 1'b0, 32'h200, 32'h7, 32'd0, 1'b0, 1'b0, 3);
    checkOutput("sw_link", 32'(link_valid), 32'd0);
    applyStimulus("sc_after_sw", 1'b1, 1'b0, 1'b1, 32'h200, 32'h8, 32'd0, 1'b0, 1'b1, 2);

    // Snoop in the same cycle as the SC check: snoop wins
    applyStimulus("ll_200e", 1'b0, 1'b1, 1'b1, 32'h200, 32'd0, 32'h12345678, 1'b0, 1'b1, 3);
    fork
      applyStimulus("sc_same_snoop", 1'b1, 1'b0, 1'b1, 32'h200, 32'h9, 32'd0, 1'b0, 1'b1, 2);
      snoopAfter(0, 32'h200);
    join

    // Snoop while SC is already in REQ: SC still commits
    load_value = 32'h0BADF00D;
    applyStimulus("ll_300", 1'b0, 1'b1, 1'b1, 32'h300, 32'd0, 32'h0BADF00D, 1'b0, 1'b1, 3);
    busy_cycles = 2;
    fork
      applyStimulus("sc_req_snoop", 1'b1, 1'b0, 1'b1, 32'h300, 32'hA, 32'd1, 1'b0, 1'b1, 5);
      snoopAfter(2, 32'h300);
    join
    checkOutput("sc_req_snoop_link", 32'(link_valid), 32'd0);

    // LL completing with a matching snoop in the same cycle keeps the link
    busy_cycles = 0; load_value = 32'h00C0FFEE;
    fork
      applyStimulus("ll_snoop_same", 1'b0, 1'b1, 1'b1, 32'h380, 32'd0, 32'h00C0FFEE, 1'b0, 1'b1, 3);
      snoopAfter(1, 32'h380);
    join
    checkOutput("ll_snoop_link", 32'(link_valid), 32'd1);
    applyStimulus("sc_380", 1'b1, 1'b0, 1'b1, 32'h380, 32'hB, 32'd1, 1'b0, 1'b1, 3);

    // RAM ERROR response
    ram_mode = 2;
    applyStimulus("lw_error", 1'b0, 1'b1, 1'b0, 32'h40, 32'd0, 32'd0, 1'b1, 1'b1, 3);
    checkOutput("error_ren_after", 32'(ramREN), 32'd0);

    // Timeout: count 0..4 in REQ, then RESP
    ram_mode = 0; load_value = 32'hCAFEF00D;
    applyStimulus("lw_plain", 1'b0, 1'b1, 1'b0, 32'h48, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1, 3);
    ram_mode = 1; r0 = ren_total;
    applyStimulus("lw_timeout", 1'b0, 1'b1, 1'b0, 32'h44, 32'd0, 32'd0, 1'b1, 1'b1, 7);
    checkOutput("timeout_ren_cycles", 32'(ren_total - r0), 32'd5);
    checkOutput("timeout_ren_after", 32'(ramREN), 32'd0);

    // Asynchronous reset in the middle of a REQ
    ram_mode = 0; load_value = 32'h11112222;
    applyStimulus("ll_400", 1'b0, 1'b1, 1'b1, 32'h400, 32'd0, 32'h11112222, 1'b0, 1'b1, 3);
    ram_mode = 1;
    dmemREN = 1'b1; dmemaddr = 32'h500;
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_ren", 32'(ramREN), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_ren", 32'(ramREN), 32'd0);
    checkOutput("rst_link", 32'(link_valid), 32'd0);
    checkOutput("rst_load", dmemload, 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    dmemREN = 1'b0;
    ram_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    d0 = dhit_total;
    repeat (10) @(negedge clk);
    checkOutput("rst_no_dhit", 32'(dhit_total - d0), 32'd0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
